sseg_scan_decoder: RTL and testbench
====================================

// Module: sseg_scan_decoder
// PURPOSE
// - Receiver for the 4-digit multiplexed common-anode seven-segment bus driven by the
//   real-time counter. Observes segment and anode lines, waits for each digit slot
//   to settle, and decodes each glyph back to BCD.
// - Publishes a coherent 4-digit snapshot once per complete scan frame.
// - Used for board-to-board time mirroring and as a self-check monitor.
// PARAMETERS
// - SETTLE_CYCLES  16        consecutive identical clk samples required before a slot is captured (>=2)
// - TIMEOUT_CYCLES 2**20     clk cycles with no capture before the partial frame is discarded
// PORTS
// - clk          in   1  system clock; single clock domain
// - rst          in   1  synchronous, active-high reset
// - a,b,c,d,e,f,g in  1  segment lines, active-low, bus order {g,f,e,d,c,b,a}
// - dp           in   1  decimal point, active-low; ignored
// - an           in   4  anode selects, active-low; an[i]=0 selects digit i (0 = least significant)
// - digit0..3    out  4  BCD snapshot of the last valid frame; 4'hF = dash
// - frame_valid  out  1  one-cycle pulse; digit0..3 updated in the same cycle
// - pattern_err  out  1  one-cycle pulse when a settled glyph is not in the code table
// - stale        out  1  level; set on timeout, cleared by the next frame_valid
// BEHAVIOUR
// - Reset: digit0..3=0, frame_valid=0, pattern_err=0, stale=0; seen mask=0, bad mask=0,
//   settle counter=0, FSM=SETTLE. Reset mid-frame discards all partial captures.
// - Input stage: {an,g..a} registered once (1-cycle delay). All decisions use the
//   registered value and compare it with its previous-cycle copy.
// - FSM SETTLE: any change of the 11-bit vector clears the counter. When the counter
//   reaches SETTLE_CYCLES-1 on an unchanged vector:
//   - If an is exactly one-hot-low, capture the slot and go to HOLD.
//   - Otherwise (1111 blank, or multiple low) do not capture and go to HOLD.
// - FSM HOLD: wait for any change of the vector, then clear the counter and return to
//   SETTLE. This gives exactly one capture per slot dwell, so a long dwell never
//   double-counts.
// - Capture of slot i: decode the glyph into shadow[i] and set seen[i].
//   - On a decode miss, pulse pattern_err on the next cycle and set bad[i].
//   - Recapturing a slot already in seen overwrites shadow[i] and bad[i]; this is legal.
// - Glyph table, active-low {g..a}:
//   - 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//   - 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000
//   - dash=0111111 -> 4'hF. Anything else is a miss.
// - Frame completion: in the cycle after a capture makes seen==4'b1111:
//   - If bad==0, copy shadow->digit0..3 and pulse frame_valid for 1 cycle.
//   - If bad!=0, leave digit outputs unchanged and do not pulse frame_valid.
//   - In both cases clear seen and bad.
// - Scan order is not checked; any order that covers all four slots completes a frame.
// - Timeout: the idle counter resets on every capture. If it reaches TIMEOUT_CYCLES-1,
//   clear seen and bad and set stale. digit outputs keep their last value.
// - Simultaneous events:
//   - Timeout in the same cycle as a capture: the capture wins and the counter resets.
//   - Capture of a glyph miss on the slot that completes the frame: pattern_err pulses
//     and frame_valid does not.
// - Latency from a slot's first stable input to its capture: 1 + SETTLE_CYCLES clk cycles.
//   frame_valid follows the fourth capture by 1 cycle.
// - Counter widths: $clog2(SETTLE_CYCLES) and $clog2(TIMEOUT_CYCLES), saturating, no wrap.
// STRUCTURE
// - Package sseg_pkg holds:
//   - localparam glyph constants GLYPH_0..GLYPH_9 and GLYPH_DASH (7-bit, active-low);
//   - the anode one-hot-low constants AN_D0..AN_D3;
//   - typedef bcd_t (logic [3:0]) and the FSM state enum {SETTLE, HOLD}.
// - Sub-module sseg_glyph_decode: combinational, 7-bit glyph -> {hit, bcd_t}. The same
//   table is reused by the encoder side.
// - Top level: input register, settle counter and FSM, shadow/seen/bad registers, timeout counter.
// TESTING
// - Reset, then drive slots 0..3 with glyphs 4,3,2,1 (an 1110,1101,1011,0111), each for 32
//   cycles -> one frame_valid; digit0=4, digit1=3, digit2=2, digit3=1; no pattern_err.
// - Same frame, but slot 1 carries a 5-cycle glitch to glyph 8 mid-dwell, then stays
//   stable >=16 cycles -> digit1 decodes the final stable glyph; one capture per dwell.
// - Slot 2 carries glyph 1111111 -> pattern_err pulses once; frame_valid does not assert;
//   digit outputs hold their previous frame value.
// - an=1111 held for 1000 cycles between slots -> no capture. A frame still completes
//   once all four slots have been shown.
// - TIMEOUT_CYCLES=256: capture slots 0 and 1, then freeze the inputs -> stale=1 at 256
//   idle cycles. The next full frame clears stale and pulses frame_valid.
// - Assert rst for 1 cycle after 3 slots are captured, then show slot 3 only -> no
//   frame_valid; all outputs back at reset values.

Source files
------------

// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared glyph, anode and state definitions for the seven-segment scan decoder
// Contents: active-low glyph constants, active-low anode selects, bcd_t, FSM state enum.
package sseg_pkg;

  // Segment glyphs, active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0    = 7'b1000000;
  localparam logic [6:0] GLYPH_1    = 7'b1111001;
  localparam logic [6:0] GLYPH_2    = 7'b0100100;
  localparam logic [6:0] GLYPH_3    = 7'b0110000;
  localparam logic [6:0] GLYPH_4    = 7'b0011001;
  localparam logic [6:0] GLYPH_5    = 7'b0010010;
  localparam logic [6:0] GLYPH_6    = 7'b0000010;
  localparam logic [6:0] GLYPH_7    = 7'b1111000;
  localparam logic [6:0] GLYPH_8    = 7'b0000000;
  localparam logic [6:0] GLYPH_9    = 7'b0010000;
  localparam logic [6:0] GLYPH_DASH = 7'b0111111;

  // Anode selects, active-low; AN_Dn drives digit n
  localparam logic [3:0] AN_D0 = 4'b1110;
  localparam logic [3:0] AN_D1 = 4'b1101;
  localparam logic [3:0] AN_D2 = 4'b1011;
  localparam logic [3:0] AN_D3 = 4'b0111;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_DASH = 4'hF;

  typedef enum logic {SETTLE, HOLD} state_t;

endpackage

// File: rtl/sseg_scan_decoder_if.sv
// rtl/sseg_scan_decoder_if.sv - multiplexed seven-segment display bus
// Signals: a..g segment lines, dp decimal point, an[3:0] anode selects (all active-low).
// master: the side driving the display; slave: the observing decoder.
interface sseg_scan_decoder_if;
  logic       a, b, c, d, e, f, g;
  logic       dp;
  logic [3:0] an;

  modport master (output a, b, c, d, e, f, g, dp, an);
  modport slave  (input  a, b, c, d, e, f, g, dp, an);
endinterface

// File: rtl/sseg_glyph_decode.sv
// rtl/sseg_glyph_decode.sv - combinational active-low glyph to BCD lookup
// Ports: glyph[6:0] in ({g..a}, active-low); hit out (glyph is in the table); bcd out (4'hF = dash).
module sseg_glyph_decode
  import sseg_pkg::*;
(
  input  logic [6:0] glyph,
  output logic       hit,
  output bcd_t       bcd
);

  always_comb begin
    hit = 1'b1;
    bcd = '0;
    case (glyph)
      GLYPH_0:    bcd = 4'd0;
      GLYPH_1:    bcd = 4'd1;
      GLYPH_2:    bcd = 4'd2;
      GLYPH_3:    bcd = 4'd3;
      GLYPH_4:    bcd = 4'd4;
      GLYPH_5:    bcd = 4'd5;
      GLYPH_6:    bcd = 4'd6;
      GLYPH_7:    bcd = 4'd7;
      GLYPH_8:    bcd = 4'd8;
      GLYPH_9:    bcd = 4'd9;
      GLYPH_DASH: bcd = BCD_DASH;
      default:    hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// rtl/sseg_scan_decoder.sv - 4-digit multiplexed seven-segment bus receiver
// Ports: clk, rst (sync, active-high); bus (slave modport: segments, dp, anodes);
//        digit0..digit3 last valid frame; frame_valid pulse; pattern_err pulse; stale level.
module sseg_scan_decoder
  import sseg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2**20
)(
  input  logic clk,
  input  logic rst,
  sseg_scan_decoder_if.slave bus,
  output bcd_t digit0,
  output bcd_t digit1,
  output bcd_t digit2,
  output bcd_t digit3,
  output logic frame_valid,
  output logic pattern_err,
  output logic stale
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic          unused_dp;
  logic [10:0]   in_q, prev_q;
  logic          changed;
  logic [3:0]    an_q;
  logic [6:0]    glyph_q;
  state_t        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          capture;
  logic [1:0]    slot;
  logic          slot_ok;
  logic          hit;
  bcd_t          bcd;
  bcd_t          shadow [4];
  logic [3:0]    seen_q, bad_q;
  logic [TW-1:0] idle_q;
  logic          complete, timeout;

  // The decimal point carries no digit information
  assign unused_dp = bus.dp;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q   <= '1;
      prev_q <= '1;
    end else begin
      in_q   <= {bus.an, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
      prev_q <= in_q;
    end
  end

  assign changed = (in_q != prev_q);
  assign an_q    = in_q[10:7];
  assign glyph_q = in_q[6:0];

  // Only an exactly one-hot-low anode names a slot; blank and multi-select are not captured
  always_comb begin
    slot    = 2'd0;
    slot_ok = 1'b1;
    case (an_q)
      AN_D0:   slot = 2'd0;
      AN_D1:   slot = 2'd1;
      AN_D2:   slot = 2'd2;
      AN_D3:   slot = 2'd3;
      default: slot_ok = 1'b0;
    endcase
  end

  sseg_glyph_decode u_decode (
    .glyph (glyph_q),
    .hit   (hit),
    .bcd   (bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SETTLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // HOLD parks after each settle decision so a long dwell yields one capture
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    capture  = 1'b0;
    case (state_q)
      SETTLE: begin
        if (changed) begin
          settle_d = '0;
        end else if (settle_q == SETTLE_LAST) begin
          capture = slot_ok;
          state_d = HOLD;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      HOLD: begin
        if (changed) begin
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  assign complete = (seen_q == 4'hF);
  // A capture in the same cycle restarts the idle count instead of timing out
  assign timeout  = !capture && (idle_q == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else if (capture) begin
      idle_q <= '0;
    end else if (idle_q != IDLE_LAST) begin
      idle_q <= idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q      <= '0;
      bad_q       <= '0;
      pattern_err <= 1'b0;
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
    end else begin
      pattern_err <= capture && !hit;
      if (capture) begin
        shadow[slot] <= bcd;
        seen_q[slot] <= 1'b1;
        bad_q[slot]  <= !hit;
      end else if (complete || timeout) begin
        seen_q <= '0;
        bad_q  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit0      <= '0;
      digit1      <= '0;
      digit2      <= '0;
      digit3      <= '0;
      frame_valid <= 1'b0;
      stale       <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (complete && bad_q == 4'b0) begin
        digit0      <= shadow[0];
        digit1      <= shadow[1];
        digit2      <= shadow[2];
        digit3      <= shadow[3];
        frame_valid <= 1'b1;
        stale       <= 1'b0;
      end else if (timeout) begin
        stale <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// tb/tb_sseg_scan_decoder.sv - self-checking bench for sseg_scan_decoder
module tb_sseg_scan_decoder;

  localparam int S       = 16;
  localparam int T_SHORT = 256;
  localparam logic [10:0] BLANK = 11'h7FF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sseg_scan_decoder_if bus ();

  logic [3:0] d0, d1, d2, d3, t0, t1, t2, t3;
  logic       fv, perr, stl, fv_t, perr_t, stl_t;

  sseg_scan_decoder #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .digit0(d0), .digit1(d1), .digit2(d2), .digit3(d3),
    .frame_valid(fv), .pattern_err(perr), .stale(stl)
  );

  sseg_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T_SHORT)) dut_t (
    .clk(clk), .rst(rst), .bus(bus),
    .digit0(t0), .digit1(t1), .digit2(t2), .digit3(t3),
    .frame_valid(fv_t), .pattern_err(perr_t), .stale(stl_t)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] glyph_tab [0:10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000, 7'b0111111};

  int          fv_cnt = 0, perr_cnt = 0, fv_t_cnt = 0;
  logic [15:0] fv_q[$];

  always begin
    @(posedge clk);
    #1;
    if (fv) begin
      fv_cnt++;
      fv_q.push_back({d3, d2, d1, d0});
    end
    if (perr) perr_cnt++;
    if (fv_t) fv_t_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] slotv(input int s, input logic [6:0] gl);
    logic [3:0] an;
    an = ~(4'b0001 << s);
    return {an, gl};
  endfunction

  function automatic int ref_bcd(input logic [6:0] gl);
    for (int i = 0; i <= 10; i++) if (glyph_tab[i] == gl) return (i == 10) ? 15 : i;
    return -1;
  endfunction

  function automatic int zeros(input logic [3:0] an);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!an[i]) n++;
    return n;
  endfunction

  task automatic set_bus(input logic [10:0] v);
    {bus.an, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} = v;
  endtask

  // dp toggles freely: it must never disturb settling
  task automatic drive(input logic [10:0] v, input int n);
    set_bus(v);
    repeat (n) begin
      bus.dp = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_bus(BLANK);
    bus.dp = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [27:0] glyphs;   // {slot3, slot2, slot1, slot0}
    int          exp_fv;
    logic [15:0] exp_digits; // {d3, d2, d1, d0}
    int          exp_err;
  } frame_vec_t;

  frame_vec_t tab [7];

  initial begin
    int          f0, e0, ft0, lat;
    logic [27:0] gw;
    logic [10:0] v, prev;
    int          dur, k, b;
    logic [3:0]  seen, bad;
    logic [3:0]  sh [4];
    logic [15:0] exp_q[$];
    int          exp_err;
    logic [15:0] last;

    tab[0] = '{{glyph_tab[1], glyph_tab[2], glyph_tab[3], glyph_tab[4]}, 1, 16'h1234, 0};
    tab[1] = '{{glyph_tab[1], 7'b1111111, glyph_tab[3], glyph_tab[4]}, 0, 16'h1234, 1};
    tab[2] = '{{glyph_tab[7], glyph_tab[8], glyph_tab[9], glyph_tab[0]}, 1, 16'h7890, 0};
    tab[3] = '{{glyph_tab[0], glyph_tab[10], glyph_tab[6], glyph_tab[5]}, 1, 16'h0F65, 0};
    tab[4] = '{{glyph_tab[2], glyph_tab[2], glyph_tab[2], 7'b0000001}, 0, 16'h0F65, 1};
    tab[5] = '{{7'b1111111, glyph_tab[3], glyph_tab[3], glyph_tab[3]}, 0, 16'h0F65, 1};
    tab[6] = '{{glyph_tab[9], glyph_tab[5], glyph_tab[1], glyph_tab[6]}, 1, 16'h9516, 0};

    do_reset();
    check("reset_digits", {d3, d2, d1, d0}, 16'h0);
    check("reset_flags", {fv, perr, stl, fv_t, perr_t, stl_t}, 6'b0);

    // Table-driven frames, slots shown 0..3 with long dwells
    for (int i = 0; i < 7; i++) begin
      f0 = fv_cnt; e0 = perr_cnt;
      gw = tab[i].glyphs;
      for (int s = 0; s < 4; s++) drive(slotv(s, gw[7*s +: 7]), 40);
      drive(BLANK, 4);
      check($sformatf("tab%0d_fv", i), fv_cnt - f0, tab[i].exp_fv);
      check($sformatf("tab%0d_err", i), perr_cnt - e0, tab[i].exp_err);
      check($sformatf("tab%0d_digits", i), {d3, d2, d1, d0}, tab[i].exp_digits);
    end

    // Glitch inside the slot 1 dwell: only the final stable glyph is taken
    f0 = fv_cnt; e0 = perr_cnt;
    drive(slotv(0, glyph_tab[4]), 40);
    drive(slotv(1, glyph_tab[3]), 8);
    drive(slotv(1, glyph_tab[8]), 5);
    drive(slotv(1, glyph_tab[3]), 20);
    drive(slotv(2, glyph_tab[2]), 40);
    drive(slotv(3, glyph_tab[1]), 40);
    drive(BLANK, 4);
    check("glitch_fv", fv_cnt - f0, 1);
    check("glitch_err", perr_cnt - e0, 0);
    check("glitch_digits", {d3, d2, d1, d0}, 16'h1234);

    // Long blank gaps between slots, out-of-order scan
    f0 = fv_cnt;
    drive(slotv(2, glyph_tab[5]), 40);
    drive(BLANK, 1000);
    drive(slotv(0, glyph_tab[7]), 40);
    drive(BLANK, 1000);
    check("blank_nofv", fv_cnt - f0, 0);
    drive(slotv(3, glyph_tab[4]), 40);
    drive(slotv(1, glyph_tab[6]), 40);
    drive(BLANK, 4);
    check("blank_fv", fv_cnt - f0, 1);
    check("blank_digits", {d3, d2, d1, d0}, 16'h4567);

    // Latency: frame_valid one cycle after the capture, capture S+1 cycles after first sample
    do_reset();
    drive(slotv(0, glyph_tab[8]), 40);
    drive(slotv(1, glyph_tab[8]), 40);
    drive(slotv(2, glyph_tab[8]), 40);
    set_bus(slotv(3, glyph_tab[8]));
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (fv && lat < 0) lat = n;
    end
    check("latency_fv", lat, S + 3);
    check("latency_digits", {d3, d2, d1, d0}, 16'h8888);

    // Timeout on the short-timeout instance
    do_reset();
    ft0 = fv_t_cnt;
    drive(slotv(0, glyph_tab[1]), 40);
    set_bus(slotv(1, glyph_tab[2]));
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (stl_t && lat < 0) lat = n;
    end
    check("timeout_stale_at", lat, S + 2 + T_SHORT);
    check("timeout_long_not_stale", stl, 1'b0);
    check("timeout_digits_kept", {t3, t2, t1, t0}, 16'h0);
    // Partial captures were discarded: slots 2,3 alone must not complete
    drive(slotv(2, glyph_tab[3]), 40);
    drive(slotv(3, glyph_tab[4]), 40);
    drive(BLANK, 4);
    check("timeout_discard", fv_t_cnt - ft0, 0);
    drive(slotv(0, glyph_tab[1]), 40);
    drive(slotv(1, glyph_tab[2]), 40);
    drive(BLANK, 4);
    check("timeout_refill_fv", fv_t_cnt - ft0, 1);
    check("timeout_stale_cleared", stl_t, 1'b0);
    check("timeout_refill_digits", {t3, t2, t1, t0}, 16'h4321);

    // Reset mid-frame drops partial captures
    drive(slotv(0, glyph_tab[9]), 40);
    drive(slotv(1, glyph_tab[9]), 40);
    drive(slotv(2, glyph_tab[9]), 40);
    f0 = fv_cnt; e0 = perr_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(slotv(3, glyph_tab[9]), 40);
    drive(BLANK, 4);
    check("midreset_nofv", fv_cnt - f0, 0);
    check("midreset_digits", {d3, d2, d1, d0}, 16'h0);
    check("midreset_flags", {stl, perr_cnt - e0}, 0);

    // Randomized segments against a transaction-level model
    do_reset();
    fv_q.delete();
    e0 = perr_cnt;
    seen = '0; bad = '0; exp_err = 0; last = '0;
    for (int i = 0; i < 4; i++) sh[i] = '0;
    prev = BLANK;
    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 9));
      if (k <= 6) begin
        v = slotv(int'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0) ? 7'($urandom) : glyph_tab[$urandom_range(0, 10)]);
      end else if (k == 7) begin
        v = BLANK;
      end else if (k == 8) begin
        v = {4'($urandom), 7'($urandom)};
        while (zeros(v[10:7]) < 2) v[10:7] = 4'($urandom);
      end else begin
        v = 11'($urandom);
      end
      if (v == prev) v[0] = ~v[0];
      dur = int'($urandom_range(3, 40));
      drive(v, dur);
      prev = v;
      // A vector held for at least S+1 samples on a single-digit anode is captured once
      if (dur >= S + 1 && zeros(v[10:7]) == 1) begin
        for (int s = 0; s < 4; s++) begin
          if (!v[7 + s]) begin
            b = ref_bcd(v[6:0]);
            seen[s] = 1'b1;
            bad[s]  = (b < 0);
            sh[s]   = (b < 0) ? 4'h0 : 4'(b);
            if (b < 0) exp_err++;
          end
        end
        if (seen == 4'hF) begin
          if (bad == 4'h0) begin
            last = {sh[3], sh[2], sh[1], sh[0]};
            exp_q.push_back(last);
          end
          seen = '0;
          bad  = '0;
        end
      end
    end
    drive((prev == BLANK) ? 11'h7FE : BLANK, 5);
    check("rand_frame_count", fv_q.size(), exp_q.size());
    check("rand_err_count", perr_cnt - e0, exp_err);
    for (int i = 0; i < exp_q.size() && i < fv_q.size(); i++)
      check($sformatf("rand_frame%0d", i), fv_q[i], exp_q[i]);
    check("rand_final_digits", {d3, d2, d1, d0}, last);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
